// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle MIPS multiply/divide unit.
//   op_e       : operation encoding on the op port
//   state_e    : sequencer states
//   MULDIV_LAT : cycles from the accepting edge of start to the edge that raises done
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam int MULDIV_LAT = 34;

endpackage

// File: rtl/muldiv_unit_adder32bit.sv
// adder32bit: 32-bit ripple-style adder shared by the ALU datapath.
//   x, y    : addends
//   c_in    : carry in
//   s       : sum
//   c_out   : carry out of bit 31
//   v       : signed overflow (carry into bit 31 xor carry out)
//   c_out2  : carry into bit 31
module adder32bit (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out,
  output logic        v,
  output logic        c_out2
);

  logic [31:0] low_sum;
  logic [1:0]  top_sum;

  always_comb begin
    low_sum = {1'b0, x[30:0]} + {1'b0, y[30:0]} + {31'b0, c_in};
    top_sum = {1'b0, x[31]} + {1'b0, y[31]} + {1'b0, low_sum[31]};
    s       = {top_sum[0], low_sum[30:0]};
    c_out   = top_sum[1];
    c_out2  = low_sum[31];
    v       = top_sum[1] ^ low_sum[31];
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 multi-cycle MULT/MULTU/DIV/DIVU producing HI/LO.
//   clk, rst_n : clock, asynchronous active-low reset
//   start, op  : request (sampled in IDLE only) and operation select
//   a, b       : rs / rt operands
//   flush      : cancel an in-flight operation, results untouched
//   busy, done : in-progress flag and one-cycle completion pulse
//   hi, lo     : result registers, written only in FIXUP
//   divz       : last divide had a zero divisor (cleared by multiplies)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divz
);

  localparam int CNT_W = $clog2(ITER);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               divz_q, divz_d;

  // Datapath: {acc_hi, acc_lo} is {high, low} for multiply and {rem, quo} for divide.
  logic [31:0]        mcand_q, mcand_d;
  logic [31:0]        acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic               is_div_q, is_div_d, is_signed_q, is_signed_d;
  logic               res_sign_q, res_sign_d, dvd_sign_q, dvd_sign_d, bzero_q, bzero_d;

  logic [31:0]        add_x, add_y, add_s;
  logic               add_cin, add_cout, add_v_unused, add_c_out2_unused;
  logic [31:0]        rem_sh, mul_s, fix_quo, fix_rem;
  logic               mul_c, div_commit;
  logic [63:0]        fix_prod;
  op_e                op_in;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? neg32(v) : v;
  endfunction

  adder32bit u_adder (
    .x      (add_x),
    .y      (add_y),
    .c_in   (add_cin),
    .s      (add_s),
    .c_out  (add_cout),
    .v      (add_v_unused),
    .c_out2 (add_c_out2_unused)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    divz_d     = divz_q;
    mcand_d    = mcand_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    is_div_d   = is_div_q;
    is_signed_d = is_signed_q;
    res_sign_d = res_sign_q;
    dvd_sign_d = dvd_sign_q;
    bzero_d    = bzero_q;
    op_in      = op_e'(op);

    // Divide shifts first, then subtracts; multiply adds the unshifted high word.
    rem_sh  = {acc_hi_q[30:0], acc_lo_q[31]};
    add_x   = is_div_q ? rem_sh : acc_hi_q;
    add_y   = is_div_q ? ~mcand_q : mcand_q;
    add_cin = is_div_q;

    mul_c   = acc_lo_q[0] & add_cout;
    mul_s   = acc_lo_q[0] ? add_s : acc_hi_q;
    // The bit shifted out of rem is the 33rd bit of the partial remainder; when it
    // is set the remainder already exceeds any 32-bit divisor, so the subtract must
    // commit even though the 32-bit adder reports no carry.
    div_commit = add_cout | acc_hi_q[31];

    fix_quo  = (is_signed_q && res_sign_q) ? neg32(acc_lo_q) : acc_lo_q;
    fix_rem  = (is_signed_q && dvd_sign_q) ? neg32(acc_hi_q) : acc_hi_q;
    fix_prod = (is_signed_q && res_sign_q) ? neg64({acc_hi_q, acc_lo_q})
                                           : {acc_hi_q, acc_lo_q};

    case (state_q)
      S_IDLE: begin
        // The done cycle still counts as busy, so a start there is dropped.
        if (start && !flush && !done_q) begin
          is_div_d    = (op_in == OP_DIV) || (op_in == OP_DIVU);
          is_signed_d = (op_in == OP_MULT) || (op_in == OP_DIV);
          res_sign_d  = a[31] ^ b[31];
          dvd_sign_d  = a[31];
          bzero_d     = (b == 32'd0);
          mcand_d     = is_div_d ? mag32(b, is_signed_d) : mag32(a, is_signed_d);
          acc_lo_d    = is_div_d ? mag32(a, is_signed_d) : mag32(b, is_signed_d);
          acc_hi_d    = 32'd0;
          cnt_d       = '0;
          state_d     = S_CALC;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          acc_hi_d = div_commit ? add_s : rem_sh;
          acc_lo_d = {acc_lo_q[30:0], div_commit};
        end else begin
          acc_hi_d = {mul_c, mul_s[31:1]};
          acc_lo_d = {mul_s[0], acc_lo_q[31:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        if (is_div_q) begin
          hi_d   = fix_rem;
          lo_d   = bzero_q ? 32'hFFFF_FFFF : fix_quo;
          divz_d = bzero_q;
        end else begin
          hi_d   = fix_prod[63:32];
          lo_d   = fix_prod[31:0];
          divz_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      divz_d  = divz_q;
    end
  end

  // Control and architectural result state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      divz_q  <= divz_d;
    end
  end

  // Iteration datapath, always reloaded before use
  always_ff @(posedge clk) begin
    mcand_q     <= mcand_d;
    acc_hi_q    <= acc_hi_d;
    acc_lo_q    <= acc_lo_d;
    is_div_q    <= is_div_d;
    is_signed_q <= is_signed_d;
    res_sign_q  <= res_sign_d;
    dvd_sign_q  <= dvd_sign_d;
    bzero_q     <= bzero_d;
  end

  assign busy = (state_q != S_IDLE) || done_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign divz = divz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: every accepted operation pushes its
// reference-model HI/LO/divz; the done monitor pops and compares.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, divz;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic        divz;
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sb_q[$];
  res_t last_res = '0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .divz  (divz)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t        r;
    longint      p;
    logic [63:0] u;
    int          sx, sy;
    r  = '0;
    sx = x;
    sy = y;
    case (o)
      2'b00: begin
        p = longint'(sx) * longint'(sy);
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      2'b01: begin
        u = {32'd0, x} * {32'd0, y};
        r.hi = u[63:32];
        r.lo = u[31:0];
      end
      2'b10: begin
        if (y == 32'd0) begin
          r.divz = 1'b1; r.lo = 32'hFFFF_FFFF; r.hi = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000; r.hi = 32'd0;
        end else begin
          r.lo = sx / sy;
          r.hi = sx % sy;
        end
      end
      default: begin
        if (y == 32'd0) begin
          r.divz = 1'b1; r.lo = 32'hFFFF_FFFF; r.hi = x;
        end else begin
          r.lo = x / y;
          r.hi = x % y;
        end
      end
    endcase
    return r;
  endfunction

  // Result monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 64'd1, 64'd0);
      end else begin
        res_t e;
        e = sb_q.pop_front();
        check_eq("hi", {32'd0, hi}, {32'd0, e.hi});
        check_eq("lo", {32'd0, lo}, {32'd0, e.lo});
        check_eq("divz", {63'd0, divz}, {63'd0, e.divz});
      end
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    check_eq("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic start_raw(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    wait_idle();
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Issue one operation, measure start-to-done latency, optionally poke start while busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit poke);
    int   lat;
    bit   busy_ok, got_done;
    res_t r;
    wait_idle();
    op = o; a = x; b = y; start = 1'b1;
    r = model(o, x, y);
    sb_q.push_back(r);
    last_res = r;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy_ok = 1'b1; got_done = 1'b0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      if (poke && (i == 5 || i == 20)) begin
        start = 1'b1; op = 2'b01; a = ~x; b = y + 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 lat++;
      if (!busy) busy_ok = 1'b0;
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check_eq("latency", 64'(lat), 64'(MULDIV_LAT));
    check_eq("busy_hold", {63'd0, busy_ok}, 64'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    check_eq("rst_divz", {63'd0, divz}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b11, 32'd100, 32'd0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'd0, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    run_op(2'b00, 32'd12345, 32'hFFFF_FF00, 1'b0);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (k[0]) ? $urandom : $urandom_range(1, 1000);
      run_op(2'(k % 4), ra, rb, 1'b0);
    end

    // start pulses during an operation must not disturb its result or issue another
    run_op(2'b01, 32'd1000, 32'd77, 1'b1);
    repeat (40) @(posedge clk);

    // flush mid-operation: busy drops, no done, results kept
    start_raw(2'b01, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check_eq("flush_busy", {63'd0, busy}, 64'd0);
    check_eq("flush_hilo", {hi, lo}, {last_res.hi, last_res.lo});
    check_eq("flush_divz", {63'd0, divz}, {63'd0, last_res.divz});
    repeat (40) @(posedge clk);

    // flush together with start in IDLE drops the start
    wait_idle();
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    check_eq("flush_start_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(posedge clk);

    // asynchronous reset mid-operation
    run_op(2'b01, 32'h0001_0003, 32'h0000_0101, 1'b0);
    start_raw(2'b00, 32'd77, 32'd99);
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", {63'd0, busy}, 64'd0);
    check_eq("arst_done", {63'd0, done}, 64'd0);
    check_eq("arst_hilo", {hi, lo}, 64'd0);
    check_eq("arst_divz", {63'd0, divz}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b01, 32'd3, 32'd5, 1'b0);

    repeat (5) @(posedge clk);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
